// File: rtl/hq_feed_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hq_feed_scheduler
// Purpose  : Buffers one 4x4 complex H matrix and replays it in q/i/j/k order
//            to the Hq multiplier, then counts Hq outputs and reports completion.
//            Optional macro HQ_FEED_PINGPONG_EN adds a second bank so the next
//            H can load while the current one replays.
// Revision : 1.0 - initial release
// ============================================================================
module hq_feed_scheduler #(
    parameter int N     = 16,
    parameter int NUM_Q = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         h_valid,
    output logic         h_ready,
    input  logic [N-1:0] h_in_r,
    input  logic [N-1:0] h_in_i,
    input  logic         run,
    output logic         mm_start,
    output logic [N-1:0] mm_h_r,
    output logic [N-1:0] mm_h_i,
    output logic         mm_h_valid,
    input  logic         mm_hq_valid,
    input  logic         mm_all_done,
    output logic         busy,
    output logic         done,
    output logic         cnt_err
);

    localparam int         C_QW       = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
    localparam logic [7:0] C_HQ_EXPECT = 8'(NUM_Q * 8);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LOADED = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [C_QW-1:0] r_q;
    logic [1:0]      r_i;
    logic            r_j;
    logic [1:0]      r_k;
    logic [7:0]      r_hq_cnt;
    logic            r_cnt_err;
    logic [2*N-1:0]  r_mm_h;
    logic            r_mm_h_valid;
    logic            w_wr_en;
    logic [3:0]      w_wr_ptr;
    logic            w_load_last;
    logic            w_swap;
    logic            w_last_elem;
    logic            w_run_entry;

`ifdef HQ_FEED_PINGPONG_EN
    localparam int C_AW = 5;
    logic            r_rd_bank;
    logic [3:0]      r_wr_ptr [2];
    logic [1:0]      r_bank_full;
    logic            w_wr_bank;
    logic [C_AW-1:0] w_wr_addr;
    logic [C_AW-1:0] w_rd_addr;

    // LOAD fills the bank about to be replayed; RUN/DRAIN fill the other one.
    assign w_wr_bank = (r_state == S_LOAD) ? r_rd_bank : ~r_rd_bank;
    assign w_wr_ptr  = r_wr_ptr[w_wr_bank];
    assign h_ready   = (r_state == S_LOAD) ||
                       (((r_state == S_RUN) || (r_state == S_DRAIN)) && !r_bank_full[~r_rd_bank]);
    assign w_wr_addr = {w_wr_bank, w_wr_ptr};
    assign w_rd_addr = {r_rd_bank, r_i, r_k};
    assign w_swap    = (r_state == S_FINISH) && r_bank_full[~r_rd_bank];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_bank   <= 1'b0;
            r_wr_ptr[0] <= 4'd0;
            r_wr_ptr[1] <= 4'd0;
            r_bank_full <= 2'b00;
        end else if (r_state == S_IDLE) begin
            r_wr_ptr[0] <= 4'd0;
            r_wr_ptr[1] <= 4'd0;
            r_bank_full <= 2'b00;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr[w_wr_bank] <= w_wr_ptr + 4'd1;
                if (w_wr_ptr == 4'd15)
                    r_bank_full[w_wr_bank] <= 1'b1;
            end
            if (w_swap) begin
                r_rd_bank              <= ~r_rd_bank;
                r_wr_ptr[r_rd_bank]    <= 4'd0;
                r_bank_full[r_rd_bank] <= 1'b0;
            end
        end
    end
`else
    localparam int C_AW = 4;
    logic [3:0]      r_wr_ptr;
    logic [C_AW-1:0] w_wr_addr;
    logic [C_AW-1:0] w_rd_addr;

    assign w_wr_ptr  = r_wr_ptr;
    assign h_ready   = (r_state == S_LOAD);
    assign w_wr_addr = w_wr_ptr;
    assign w_rd_addr = {r_i, r_k};
    assign w_swap    = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wr_ptr <= 4'd0;
        else if (r_state == S_IDLE)
            r_wr_ptr <= 4'd0;
        else if (w_wr_en)
            r_wr_ptr <= r_wr_ptr + 4'd1;
    end
`endif

    logic [2*N-1:0] r_buf [2**C_AW];

    assign w_wr_en     = h_valid && h_ready;
    assign w_load_last = (r_state == S_LOAD) && w_wr_en && (w_wr_ptr == 4'd15);
    assign w_run_entry = (r_state == S_LOADED) && run;
    assign w_last_elem = (r_q == C_QW'(NUM_Q - 1)) && (r_i == 2'd3) && r_j && (r_k == 2'd3);

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_buf[w_wr_addr] <= {h_in_r, h_in_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        mm_start    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy        = 1'b0;
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (w_load_last)
                    w_state_nxt = S_LOADED;
            end
            S_LOADED: begin
                if (run)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                mm_start = 1'b1;
                if (w_last_elem)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                mm_start = 1'b1;
                if (mm_all_done)
                    w_state_nxt = S_FINISH;
            end
            S_FINISH: begin
                done        = 1'b1;
                w_state_nxt = w_swap ? S_LOADED : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Element registered in RUN cycle n appears on mm_h in cycle n+1,
    // giving the one-cycle gap after mm_start rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q          <= '0;
            r_i          <= 2'd0;
            r_j          <= 1'b0;
            r_k          <= 2'd0;
            r_mm_h       <= '0;
            r_mm_h_valid <= 1'b0;
        end else if (w_run_entry) begin
            r_q          <= '0;
            r_i          <= 2'd0;
            r_j          <= 1'b0;
            r_k          <= 2'd0;
            r_mm_h_valid <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_mm_h       <= r_buf[w_rd_addr];
            r_mm_h_valid <= 1'b1;
            r_k          <= r_k + 2'd1;
            if (r_k == 2'd3) begin
                r_j <= ~r_j;
                if (r_j) begin
                    r_i <= r_i + 2'd1;
                    if (r_i == 2'd3)
                        r_q <= r_q + 1'b1;
                end
            end
        end else begin
            r_mm_h_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_hq_cnt <= 8'd0;
        else if (w_run_entry)
            r_hq_cnt <= 8'd0;
        else if (((r_state == S_RUN) || (r_state == S_DRAIN)) && mm_hq_valid && (r_hq_cnt != 8'hFF))
            r_hq_cnt <= r_hq_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt_err <= 1'b0;
        else if (r_state == S_IDLE)
            r_cnt_err <= 1'b0;
        else if ((r_state == S_FINISH) && (r_hq_cnt != C_HQ_EXPECT))
            r_cnt_err <= 1'b1;
    end

    // Visible in the same cycle as done, then held sticky.
    assign cnt_err    = r_cnt_err || ((r_state == S_FINISH) && (r_hq_cnt != C_HQ_EXPECT));
    assign mm_h_r     = r_mm_h[2*N-1:N];
    assign mm_h_i     = r_mm_h[N-1:0];
    assign mm_h_valid = r_mm_h_valid;

endmodule
`default_nettype wire

// File: tb/tb_hq_feed_scheduler.sv
`default_nettype none
// Testbench for hq_feed_scheduler: randomized load/replay against a
// reference model computed from the replay ordering rules.
module tb_hq_feed_scheduler;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         h_valid = 1'b0;
    logic         h_ready;
    logic [N-1:0] h_in_r = '0;
    logic [N-1:0] h_in_i = '0;
    logic         run = 1'b0;
    logic         mm_start;
    logic [N-1:0] mm_h_r;
    logic [N-1:0] mm_h_i;
    logic         mm_h_valid;
    logic         mm_hq_valid = 1'b0;
    logic         mm_all_done = 1'b0;
    logic         busy;
    logic         done;
    logic         cnt_err;

    int checks = 0;
    int fails  = 0;

    logic [N-1:0] ld_r [16];
    logic [N-1:0] ld_i [16];
    logic [N-1:0] exp_r [16];
    logic [N-1:0] exp_i [16];

    hq_feed_scheduler #(.N(N), .NUM_Q(16)) dut (
        .clk(clk), .rst_n(rst_n), .h_valid(h_valid), .h_ready(h_ready),
        .h_in_r(h_in_r), .h_in_i(h_in_i), .run(run), .mm_start(mm_start),
        .mm_h_r(mm_h_r), .mm_h_i(mm_h_i), .mm_h_valid(mm_h_valid),
        .mm_hq_valid(mm_hq_valid), .mm_all_done(mm_all_done),
        .busy(busy), .done(done), .cnt_err(cnt_err)
    );

    always #5 clk = ~clk;

    // Beat n targets row i = (n/8)%4, column k = n%4; q and j only repeat the row.
    function automatic logic [2*N-1:0] exp_beat(input int n);
        int i, k;
        i = (n / 8) % 4;
        k = n % 4;
        return {exp_r[i*4+k], exp_i[i*4+k]};
    endfunction

    task automatic fill_random();
        for (int e = 0; e < 16; e++) begin
            ld_r[e] = N'($urandom);
            ld_i[e] = N'($urandom);
        end
    endtask

    task automatic commit_model();
        for (int e = 0; e < 16; e++) begin
            exp_r[e] = ld_r[e];
            exp_i[e] = ld_i[e];
        end
    endtask

    task automatic load_h();
        int idx = 0;
        int cyc = 0;
        while (idx < 16 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            h_valid = 1'($urandom_range(0, 1));
            if (h_ready) begin
                h_in_r = ld_r[idx];
                h_in_i = ld_i[idx];
                if (h_valid) idx++;
            end else begin
                h_in_r = N'($urandom);
                h_in_i = N'($urandom);
            end
        end
        checks++;
        if (idx !== 16) begin
            fails++;
            $display("FAIL load_count got=%0d exp=16", idx);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({h_ready, busy} !== 2'b01) begin
                fails++;
                $display("FAIL loaded_ready got h_ready=%b busy=%b exp h_ready=0 busy=1", h_ready, busy);
            end
            h_valid = 1'b1;
            h_in_r  = N'($urandom);
            h_in_i  = N'($urandom);
        end
        h_valid = 1'b0;
    endtask

    task automatic run_seq(input int pulses, input bit feed, input int abort_at);
        int pc = 0;
        int nfeed = 0;
        logic exp_err;
        exp_err = (pulses != 128);
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        checks++;
        if ({mm_start, mm_h_valid} !== 2'b10) begin
            fails++;
            $display("FAIL run_entry got start=%b valid=%b exp start=1 valid=0", mm_start, mm_h_valid);
        end
        for (int n = 0; n < 512; n++) begin
            @(negedge clk);
            checks++;
            if ({mm_h_valid, mm_h_r, mm_h_i} !== {1'b1, exp_beat(n)}) begin
                fails++;
                $display("FAIL beat%0d got valid=%b h=%h_%h exp valid=1 h=%h", n, mm_h_valid, mm_h_r, mm_h_i, exp_beat(n));
            end
            mm_hq_valid = ((n % 4) == 3) && (pc < pulses);
            if (mm_hq_valid) pc++;
            mm_all_done = (n >= 100) && (n < 103);
            if (feed && nfeed < 16 && h_ready) begin
                h_valid = 1'($urandom_range(0, 1));
                h_in_r  = ld_r[nfeed];
                h_in_i  = ld_i[nfeed];
                if (h_valid) nfeed++;
            end else begin
                h_valid = 1'b0;
            end
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if ({h_ready, mm_start, mm_h_r, mm_h_i, mm_h_valid, busy, done, cnt_err} !== '0) begin
                    fails++;
                    $display("FAIL async_reset got ready=%b start=%b h=%h_%h valid=%b busy=%b done=%b err=%b exp all 0",
                             h_ready, mm_start, mm_h_r, mm_h_i, mm_h_valid, busy, done, cnt_err);
                end
                mm_hq_valid = 1'b0;
                mm_all_done = 1'b0;
                h_valid     = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        @(negedge clk);
        mm_hq_valid = 1'b0;
        h_valid     = 1'b0;
        checks++;
        if ({mm_h_valid, mm_h_r, mm_h_i, mm_start, done} !== {1'b0, exp_beat(511), 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL drain_hold got valid=%b h=%h_%h start=%b done=%b exp valid=0 h=%h start=1 done=0",
                     mm_h_valid, mm_h_r, mm_h_i, mm_start, done, exp_beat(511));
        end
        if (feed) begin
            checks++;
            if (nfeed !== 16) begin
                fails++;
                $display("FAIL overlap_load got=%0d exp=16", nfeed);
            end
        end
        repeat ($urandom_range(1, 4)) @(negedge clk);
        checks++;
        if ({mm_start, done} !== 2'b10) begin
            fails++;
            $display("FAIL drain_wait got start=%b done=%b exp start=1 done=0", mm_start, done);
        end
        mm_all_done = 1'b1;
        @(negedge clk);
        mm_all_done = 1'b0;
        checks++;
        if ({mm_start, done, cnt_err} !== {1'b0, 1'b1, exp_err}) begin
            fails++;
            $display("FAIL finish got start=%b done=%b err=%b exp start=0 done=1 err=%b", mm_start, done, cnt_err, exp_err);
        end
        @(negedge clk);
        checks++;
        if (feed) begin
            if ({done, busy, h_ready} !== 3'b010) begin
                fails++;
                $display("FAIL swap_loaded got done=%b busy=%b ready=%b exp done=0 busy=1 ready=0", done, busy, h_ready);
            end
        end else begin
            if ({done, busy, cnt_err} !== {2'b00, exp_err}) begin
                fails++;
                $display("FAIL idle_after got done=%b busy=%b err=%b exp done=0 busy=0 err=%b", done, busy, cnt_err, exp_err);
            end
            @(negedge clk);
            checks++;
            if ({h_ready, busy, cnt_err} !== 3'b110) begin
                fails++;
                $display("FAIL load_entry got ready=%b busy=%b err=%b exp ready=1 busy=1 err=0", h_ready, busy, cnt_err);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({h_ready, mm_start, mm_h_r, mm_h_i, mm_h_valid, busy, done, cnt_err} !== '0) begin
            fails++;
            $display("FAIL reset_state got ready=%b start=%b h=%h_%h valid=%b busy=%b done=%b err=%b exp all 0",
                     h_ready, mm_start, mm_h_r, mm_h_i, mm_h_valid, busy, done, cnt_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({h_ready, busy} !== 2'b11) begin
            fails++;
            $display("FAIL idle_to_load got ready=%b busy=%b exp ready=1 busy=1", h_ready, busy);
        end
    endtask

    task automatic test_ramp_replay();
        for (int e = 0; e < 16; e++) begin
            ld_r[e] = N'(e);
            ld_i[e] = N'(-e);
        end
        load_h();
        commit_model();
        run_seq(128, 1'b0, -1);
    endtask

    task automatic test_short_count();
        fill_random();
        load_h();
        commit_model();
        run_seq(127, 1'b0, -1);
    endtask

    task automatic test_random_loads();
        for (int t = 0; t < 2; t++) begin
            fill_random();
            load_h();
            commit_model();
            run_seq(128, 1'b0, -1);
        end
    endtask

    task automatic test_reset_mid_run();
        fill_random();
        load_h();
        commit_model();
        run_seq(128, 1'b0, 200);
        fill_random();
        load_h();
        commit_model();
        run_seq(128, 1'b0, -1);
    endtask

`ifdef HQ_FEED_PINGPONG_EN
    task automatic test_pingpong();
        fill_random();
        load_h();
        commit_model();
        fill_random();
        run_seq(128, 1'b1, -1);
        commit_model();
        run_seq(128, 1'b0, -1);
    endtask
`endif

    initial begin
        test_reset();
        test_ramp_replay();
        test_short_count();
        test_random_loads();
        test_reset_mid_run();
`ifdef HQ_FEED_PINGPONG_EN
        test_pingpong();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
